if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter PC_RESET, default `PC_INITIAL, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction-buffer entries; it also sets the request credit limit.
REQ-003 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 rstn  input  1  reset; one clock, synchronous, active-low.
REQ-005 branch_flag  input  1  redirect request from hazard control.
REQ-006 branch_address  input  32  redirect target, word-aligned.
REQ-007 if_stop  input  1  hold: the ID stage does not consume this cycle.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address, equal to the current fetch PC.
REQ-010 imem_gnt  input  1  request accepted this cycle (handshake = imem_req && imem_gnt).
REQ-011 imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 if_valid  output  1  if_instr and if_pc valid toward ID.
REQ-014 if_pc  output  32  PC of the presented instruction.
REQ-015 if_instr  output  32  presented instruction.

Function
REQ-016 FSM states: BOOT, RUN, DRAIN; BOOT shall last exactly 1 cycle after reset release, then go to RUN.
REQ-017 imem_req shall be 1 only in RUN, with no branch_flag this cycle, and with outstanding + fifo_count < FIFO_DEPTH.
REQ-018 On a handshake: fetch PC += 4 (mod 2^32, wraps 0xFFFFFFFC -> 0); the issued PC is pushed to a tag queue; outstanding += 1.
REQ-019 In RUN, imem_rvalid shall pop the tag queue, push {tag PC, imem_rdata} into the FIFO, and decrement outstanding; the credit rule guarantees the FIFO never overflows.
REQ-020 if_valid = FIFO non-empty; if_pc and if_instr come from the FIFO head.
REQ-021 FIFO pops when if_valid && !if_stop; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-022 While if_stop = 1, the head entry shall be held stable; fetching continues up to the credit limit.
REQ-023 branch_flag = 1 (independent of if_stop): fetch PC <= branch_address, FIFO flushed, no request that cycle, responses that cycle discarded.
REQ-024 On redirect, if the post-cycle outstanding count (including a response arriving that cycle) is > 0, go to DRAIN; otherwise stay in RUN.
REQ-025 DRAIN: no requests; every imem_rvalid is discarded and decrements outstanding; return to RUN the cycle after outstanding reaches 0.
REQ-026 branch_flag in DRAIN: fetch PC updated to the new target, remain in DRAIN.
REQ-027 Simultaneous grant and response in RUN: outstanding unchanged, tag queue pushes and pops.
REQ-028 First instruction reaches if_valid no earlier than 2 cycles after its grant (1-cycle memory + FIFO register).
REQ-029 imem_rvalid with outstanding = 0 is a protocol error: ignored, no state change.

Reset
REQ-030 When rstn = 0 at a clock edge: fetch PC = PC_RESET, state = BOOT, FIFO empty, tag queue empty, outstanding = 0.
REQ-031 Output values in reset: if_valid = 0, imem_req = 0, imem_addr = PC_RESET, if_pc = 0, if_instr = `NOP` encoding (0x00000013).
REQ-032 Reset asserted mid-operation abandons in-flight requests; responses arriving during reset or BOOT are discarded.

Structure
REQ-033 PC_INITIAL, the NOP encoding, ENABLE/DISABLE, and the FSM state encodings belong in ctrl_encode_def.vh.
REQ-034 One sub-module, fetch_fifo (parameterised width and depth, push/pop/flush, count), instantiated twice: instruction buffer and tag queue.

Verification
REQ-035 Reset release, imem_gnt = 1, 1-cycle memory returning addr-as-data -> imem_addr 0x0, 0x4, ...; if_pc = 0x0 with if_instr = 0x0 valid 2 cycles after the first grant; back-to-back thereafter.
REQ-036 if_stop held 5 cycles in steady stream -> head stable; at most 2 entries buffered; imem_req low once credits are exhausted; stream resumes in order with no loss or duplicate.
REQ-037 branch_flag = 1, branch_address = 0x100, with 2 requests outstanding -> FSM in DRAIN; both stale responses dropped; next imem_addr = 0x100; if_pc 0x100 is the first valid instruction.
REQ-038 branch_flag asserted together with if_stop = 1 -> FIFO flushed; if_valid = 0 next cycle; fetch resumes at the target.
REQ-039 Fetch PC 0xFFFFFFFC granted -> next imem_addr = 0x00000000.
REQ-040 rstn low for 1 cycle mid-stream with 1 request outstanding -> all outputs at reset values; late response ignored; fetch restarts at PC_RESET.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: reset PC, NOP word, enable levels,
// FSM state encoding and the instruction-buffer entry layout.
package if_fetch_pkg;

    localparam logic [31:0] PC_INITIAL = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic        ENABLE     = 1'b1;
    localparam logic        DISABLE    = 1'b0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Register-based FIFO with flush; head is visible combinationally, push lands next cycle.
// Push is ignored when full unless a pop frees the slot the same cycle; flush wins over both.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: credit-limited requests to imem, in-order responses tagged with their PC
// and buffered toward ID; first instruction valid 2 cycles after grant; if_stop holds the head.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_INITIAL,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        branch_flag,
    input  logic [31:0] branch_address,
    input  logic        if_stop,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] ibuf_cnt, tag_cnt;
    ibuf_entry_t  ibuf_head, ibuf_push_dat;
    logic [31:0]  tag_head;
    logic         hs, rsp_ok, credit_ok;
    logic         ibuf_push, ibuf_pop, tag_pop, flush;

    // Credits cover both in-flight requests and already-buffered entries, so a
    // stalled ID stage throttles fetch before the buffer could overflow.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, ibuf_cnt}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_req  = (state_q == ST_RUN) && !branch_flag && credit_ok;
    assign imem_addr = pc_q;
    assign hs        = imem_req && imem_gnt;
    assign rsp_ok    = imem_rvalid && (outst_q != '0);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        outst_d   = outst_q;
        ibuf_push = DISABLE;
        tag_pop   = DISABLE;
        flush     = DISABLE;
        if (hs) begin
            pc_d = pc_q + 32'd4;
        end
        if (hs && !rsp_ok) begin
            outst_d = outst_q + CW'(1);
        end else if (!hs && rsp_ok) begin
            outst_d = outst_q - CW'(1);
        end
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (branch_flag) begin
                    flush   = ENABLE;
                    pc_d    = branch_address;
                    state_d = (outst_d != '0) ? ST_DRAIN : ST_RUN;
                end else if (rsp_ok && (tag_cnt != '0)) begin
                    ibuf_push = ENABLE;
                    tag_pop   = ENABLE;
                end
            end
            ST_DRAIN: begin
                if (branch_flag) begin
                    pc_d = branch_address;
                end else if (outst_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= PC_RESET;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
        end
    end

    assign ibuf_push_dat.pc    = tag_head;
    assign ibuf_push_dat.instr = imem_rdata;
    assign ibuf_pop            = (ibuf_cnt != '0) && !if_stop;

    fetch_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .push     (ibuf_push),
        .push_dat (ibuf_push_dat),
        .pop      (ibuf_pop),
        .head_dat (ibuf_head),
        .count    (ibuf_cnt)
    );

    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tagq (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .push     (hs),
        .push_dat (pc_q),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .count    (tag_cnt)
    );

    assign if_valid = (ibuf_cnt != '0);
    assign if_pc    = if_valid ? ibuf_head.pc : 32'h0;
    assign if_instr = if_valid ? ibuf_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a 1-cycle addr-as-data memory model that can be
// switched to manual response control.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk, rstn, branch_flag, if_stop;
    logic        imem_req, imem_gnt, imem_rvalid, if_valid;
    logic [31:0] branch_address, imem_addr, imem_rdata, if_pc, if_instr;
    logic        mem_auto;
    logic [31:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    if_fetch #(.PC_RESET(32'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .branch_flag    (branch_flag),
        .branch_address (branch_address),
        .if_stop        (if_stop),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // One clock; in auto mode a grant this cycle becomes a response next cycle.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem_req && imem_gnt;
        a  = imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (mem_auto) begin
            imem_rvalid = hs;
            imem_rdata  = a;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 0;
        step();
        step();
        rstn = 1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0h want 0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %0h want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %0h want 0", imem_addr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %0h want 0", if_pc); end
        checks++; if (if_instr !== 32'h13) begin errors++; $display("FAIL reset_if_instr got %0h want 13", if_instr); end
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_one_cycle imem_req got %0h want 1", imem_req); end
    endtask

    task automatic test_spurious();
        mem_auto = 0;
        imem_rvalid = 1;
        imem_rdata = 32'h0000_0BAD;
        step();
        imem_rvalid = 0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL spurious_if_valid got %0h want 0", if_valid); end
        checks++; if (dut.outst_q !== 2'd0) begin errors++; $display("FAIL spurious_outstanding got %0d want 0", dut.outst_q); end
    endtask

    task automatic test_stream();
        int seen = 0;
        mem_auto = 1;
        imem_gnt = 1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got %0h/%0h want 1/0", imem_req, imem_addr); end
        step();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h4) begin errors++; $display("FAIL stream_c1 got valid %0h addr %0h want 0/4", if_valid, imem_addr); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL stream_first_instr got %0h pc %0h instr %0h want 1/0/0", if_valid, if_pc, if_instr); end
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (if_valid) begin
                checks++; if (if_pc !== exp_pc || if_instr !== exp_pc) begin errors++; $display("FAIL stream_order got %0h/%0h want %0h", if_pc, if_instr, exp_pc); end
                exp_pc += 32'd4;
                seen++;
            end
            step();
        end
        checks++; if (seen < 6) begin errors++; $display("FAIL stream_throughput got %0d want >=6", seen); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        for (int i = 0; i < 10 && !if_valid; i++) step();
        checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin errors++; $display("FAIL stall_head_pre got %0h/%0h want 1/%0h", if_valid, if_pc, exp_pc); end
        held = exp_pc;
        if_stop = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (if_valid !== 1'b1 || if_pc !== held || if_instr !== held) begin errors++; $display("FAIL stall_head got %0h/%0h want %0h", if_pc, if_instr, held); end
            checks++; if (dut.ibuf_cnt > 2'd2) begin errors++; $display("FAIL stall_buffered got %0d want <=2", dut.ibuf_cnt); end
            if (i >= 2) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %0h want 0", imem_req); end
            end
        end
        if_stop = 0;
        for (int i = 0; i < 12; i++) begin
            if (if_valid) begin
                checks++; if (if_pc !== exp_pc || if_instr !== exp_pc) begin errors++; $display("FAIL stall_resume got %0h/%0h want %0h", if_pc, if_instr, exp_pc); end
                exp_pc += 32'd4;
            end
            step();
        end
    endtask

    task automatic test_branch_drain();
        bit got = 0;
        mem_auto = 0; imem_rvalid = 0; imem_gnt = 0; if_stop = 0;
        rstn = 0; step(); rstn = 1; step();
        imem_gnt = 1;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_credit_req got %0h want 0", imem_req); end
        imem_gnt = 0; branch_flag = 1; branch_address = 32'h100;
        step();
        branch_flag = 0;
        checks++; if (dut.state_q !== ST_DRAIN || imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL drain_enter got st %0d req %0h addr %0h want 2/0/100", dut.state_q, imem_req, imem_addr); end
        imem_rvalid = 1; imem_rdata = 32'hDEAD_0000;
        step();
        checks++; if (dut.state_q !== ST_DRAIN || imem_req !== 1'b0) begin errors++; $display("FAIL drain_hold got st %0d req %0h want 2/0", dut.state_q, imem_req); end
        imem_rdata = 32'hDEAD_0004;
        step();
        imem_rvalid = 0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_stale_dropped got %0h want 0", if_valid); end
        for (int i = 0; i < 3 && !got; i++) begin
            if (imem_req) got = 1; else step();
        end
        checks++; if (!got || imem_addr !== 32'h100) begin errors++; $display("FAIL drain_resume_addr got %0h/%0h want 1/100", got, imem_addr); end
        imem_gnt = 1;
        step();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hABCD_0100;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_no_early_valid got %0h want 0", if_valid); end
        step();
        imem_rvalid = 0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hABCD_0100) begin errors++; $display("FAIL drain_first_instr got %0h/%0h/%0h want 1/100/abcd0100", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_branch_stop();
        bit got = 0;
        mem_auto = 1; imem_gnt = 1;
        for (int i = 0; i < 10 && !if_valid; i++) step();
        if_stop = 1; branch_flag = 1; branch_address = 32'h200;
        step();
        branch_flag = 0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bstop_flushed got %0h want 0", if_valid); end
        if_stop = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (if_valid) got = 1; else step();
        end
        checks++; if (!got || if_pc !== 32'h200 || if_instr !== 32'h200) begin errors++; $display("FAIL bstop_target got %0h pc %0h instr %0h want 1/200/200", got, if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        bit wrap_now;
        bit wrap_seen = 0;
        int seen = 0;
        branch_flag = 1; branch_address = 32'hFFFF_FFF8;
        step();
        branch_flag = 0;
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 30; i++) begin
            wrap_now = imem_req && imem_gnt && (imem_addr == 32'hFFFF_FFFC);
            if (if_valid) begin
                checks++; if (if_pc !== exp_pc || if_instr !== exp_pc) begin errors++; $display("FAIL wrap_order got %0h/%0h want %0h", if_pc, if_instr, exp_pc); end
                exp_pc += 32'd4;
                seen++;
            end
            step();
            if (wrap_now) begin
                wrap_seen = 1;
                checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %0h want 0", imem_addr); end
            end
        end
        checks++; if (!wrap_seen || seen < 3) begin errors++; $display("FAIL wrap_progress got %0h/%0d want 1/>=3", wrap_seen, seen); end
    endtask

    task automatic test_reset_mid();
        mem_auto = 0; imem_rvalid = 0; imem_gnt = 0;
        rstn = 0; step(); rstn = 1; step();
        imem_gnt = 1;
        step();
        imem_rvalid = 1; imem_rdata = 32'h0;
        step();
        imem_rvalid = 0; imem_gnt = 0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || dut.outst_q !== 2'd1) begin errors++; $display("FAIL rmid_pre got %0h/%0h/%0d want 1/0/1", if_valid, if_pc, dut.outst_q); end
        if_stop = 1;
        imem_rvalid = 1; imem_rdata = 32'hBAD0_0004;
        rstn = 0;
        step();
        rstn = 1; if_stop = 0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rmid_if_valid got %0h want 0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_imem_req got %0h want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_imem_addr got %0h want 0", imem_addr); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h13) begin errors++; $display("FAIL rmid_if_out got %0h/%0h want 0/13", if_pc, if_instr); end
        step();
        imem_rvalid = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_restart got %0h/%0h/%0h want 1/0/0", imem_req, imem_addr, if_valid); end
        mem_auto = 1; imem_gnt = 1;
        step();
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL rmid_first_instr got %0h/%0h/%0h want 1/0/0", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        rstn = 0; branch_flag = 0; branch_address = 0; if_stop = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; mem_auto = 1; exp_pc = 0;
        test_reset();
        test_spurious();
        test_stream();
        test_stall();
        test_branch_drain();
        test_branch_stop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
